// File: rtl/serial_adder_pkg.sv
// Shared constants and FSM encoding for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// Full adder built from two half-adder cells plus an OR of their carries.
module full_adder_cell (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a     (A),
    .b     (B),
    .sum   (s0),
    .carry (c0)
  );

  half_adder u_ha1 (
    .a     (s0),
    .b     (Cin),
    .sum   (Sum),
    .carry (c1)
  );

  assign Cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Combinational half-adder cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, valid/ready on both sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s;
  logic             fa_c;

  full_adder_cell u_fa (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .Sum  (fa_s),
    .Cout (fa_c)
  );

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        carry_d = fa_c;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        // New bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB result.
        sum_d   = WIDTH'({fa_s, sum_q} >> 1);
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_c;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
  logic [0:0] a1, b1, sum1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;

  // Accept monitor for the 8-bit instance.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid8 && in_ready8) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transaction on the 8-bit DUT; ends one negedge after out_valid is seen.
  task automatic add8(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                      input logic [7:0] es, input logic ec, input string tag,
                      output int lat, output int low);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_rdy"}, 64'(in_ready8), 64'd1);
    a8 = ta;
    b8 = tbv;
    cin8 = tc;
    in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    low = 0;
    while (!out_valid8 && lat < 40) begin
      if (!in_ready8) low++;
      @(negedge clk);
      lat++;
    end
    if (!in_ready8) low++;
    check_eq({tag, "_lat"}, 64'(lat), 64'd8);
    check_eq({tag, "_sum"}, 64'(sum8), 64'(es));
    check_eq({tag, "_cout"}, 64'(cout8), 64'(ec));
    @(negedge clk);
    if (!in_ready8) low++;
  endtask

  logic [7:0] va[4]  = '{8'h12, 8'h80, 8'hAA, 8'h01};
  logic [7:0] vb[4]  = '{8'h34, 8'h80, 8'h55, 8'hFE};
  logic       vc[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] vs[4]  = '{8'h46, 8'h00, 8'h00, 8'hFF};
  logic       vco[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0] e1[8]  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, low, n, prev, last, acc0;
    logic [7:0] ra, rb;
    logic rc;
    logic [8:0] e;
    rst_n = 1'b1;
    {in_valid8, cin8, in_valid1, cin1} = '0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    out_ready8 = 1'b1;
    out_ready1 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ready", 64'(in_ready8), 64'd1);
    check_eq("rst_valid", 64'(out_valid8), 64'd0);
    check_eq("rst_sum", 64'(sum8), 64'd0);
    check_eq("rst_cout", 64'(cout8), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-shift: 07+07 leaves partial sum bits and a live carry after 3 shifts.
    @(negedge clk);
    a8 = 8'h07; b8 = 8'h07; cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(out_valid8), 64'd0);
    check_eq("mid_rst_ready", 64'(in_ready8), 64'd1);
    check_eq("mid_rst_sum", 64'(sum8), 64'd0);
    check_eq("mid_rst_cout", 64'(cout8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    add8(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, "post_rst", lat, low);

    // Basic add with latency and in_ready-low window.
    add8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "basic", lat, low);
    check_eq("basic_low", 64'(low), 64'd9);

    // Carry ripple.
    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ripple1", lat, low);
    add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ripple2", lat, low);

    // Backpressure with ignored in_valid pulses.
    out_ready8 = 1'b0;
    add8(8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0, "bp", lat, low);
    acc0 = acc_cnt;
    for (int k = 0; k < 20; k++) begin
      in_valid8 = (k % 5 == 0);
      a8 = 8'h11; b8 = 8'h22;
      @(negedge clk);
      check_eq("bp_sum", 64'(sum8), 64'hFF);
      check_eq("bp_cout", 64'(cout8), 64'd0);
      check_eq("bp_valid", 64'(out_valid8), 64'd1);
      check_eq("bp_ready", 64'(in_ready8), 64'd0);
    end
    in_valid8 = 1'b0;
    check_eq("bp_no_accept", 64'(acc_cnt - acc0), 64'd0);
    out_ready8 = 1'b1;
    @(negedge clk);
    check_eq("bp_rel_valid", 64'(out_valid8), 64'd0);
    check_eq("bp_rel_ready", 64'(in_ready8), 64'd1);
    check_eq("bp_rel_sum", 64'(sum8), 64'hFF);

    // Back-to-back with in_valid held high.
    a8 = va[0]; b8 = vb[0]; cin8 = vc[0]; in_valid8 = 1'b1;
    prev = acc_cnt;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (acc_cnt == prev && n < 40) begin
        @(negedge clk);
        n++;
      end
      check_eq("b2b_accept", 64'(acc_cnt - prev), 64'd1);
      prev = acc_cnt;
      if (i > 0) check_eq("b2b_gap", 64'(acc_cyc - last), 64'd10);
      last = acc_cyc;
      if (i < 3) begin
        a8 = va[i+1]; b8 = vb[i+1]; cin8 = vc[i+1];
      end else begin
        in_valid8 = 1'b0;
      end
      n = 0;
      while (!out_valid8 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check_eq("b2b_sum", 64'(sum8), 64'(vs[i]));
      check_eq("b2b_cout", 64'(cout8), 64'(vco[i]));
    end

    // WIDTH=1 exhaustive.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("w1_ready", 64'(in_ready1), 64'd1);
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
      in_valid1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid1 = 1'b0;
      check_eq("w1_early", 64'(out_valid1), 64'd0);
      @(negedge clk);
      check_eq("w1_valid", 64'(out_valid1), 64'd1);
      check_eq("w1_result", 64'({cout1, sum1}), 64'(e1[i]));
    end

    // Random WIDTH=8 against an arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      e = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      add8(ra, rb, rc, e[7:0], e[8], "rnd", lat, low);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder. Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Adds one bit per clock, LSB first, through a single full-adder cell built from two half-adder cells. A carry flip-flop links successive bits.
- Presents the WIDTH-bit sum and carry-out on a valid/ready output port.
- Sits downstream of the combinational half-adder cell and consumes its Sum/Carry. Trades area for latency in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b and cin are valid this cycle.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  sum and cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result bits (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values, asserted at any time including mid-operation:
  - state = IDLE; in_ready = 1; out_valid = 0; sum = 0; cout = 0.
  - Operand shift registers, carry flip-flop and bit counter = 0.
  - Any in-flight operation is discarded with no partial output.
- State IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid = 1: capture a → a_sh, b → b_sh, cin → carry; clear counter; go to SHIFT.
  - in_valid = 0: stay in IDLE.
- State SHIFT:
  - in_ready = 0. in_valid and operand inputs are ignored.
  - Each edge: compute s = a_sh[0] ^ b_sh[0] ^ carry and c = majority(a_sh[0], b_sh[0], carry) via the full-adder cell.
  - Register c into carry. Shift a_sh and b_sh right by one.
  - Shift s into the sum register MSB-first (right shift, s into bit WIDTH-1). After WIDTH shifts, bit 0 holds the original LSB result.
  - Increment counter.
  - On the edge where counter reaches WIDTH-1 (the WIDTH-th shift), load cout from c and go to DONE.
- State DONE:
  - out_valid = 1. sum and cout are stable and must not change while out_valid = 1 and out_ready = 0 (backpressure held indefinitely).
  - On an edge with out_ready = 1: go to IDLE; out_valid drops. sum and cout keep their last values until the next result completes.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
- Throughput: with out_ready tied high, minimum initiation interval is WIDTH+2 cycles (accept, WIDTH shifts, DONE handoff). No accept in DONE, even in the same cycle as out_ready.
- sum is visible during SHIFT but is meaningful only when out_valid = 1.
- WIDTH = 1: SHIFT lasts one cycle; cout = majority(a, b, cin).
- Arithmetic is unsigned. {cout, sum} equals a + b + cin exactly, in WIDTH+1 bits.

Decomposition:
- Shared header file (`include`):
  - State encodings: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2; 2'd3 is illegal and recovers to IDLE.
  - Default WIDTH constant.
- One sub-module, full_adder_cell: two halfAdder instances plus an OR of their carries; ports A, B, Cin, Sum, Cout.
- serial_adder instantiates exactly one full_adder_cell.

Test Plan (WIDTH = 8 unless noted):
1. Reset behaviour: assert rst_n = 0 mid-SHIFT after 3 shifts → out_valid = 0, in_ready = 1, sum = 0, cout = 0 immediately (asynchronous). Release, then accept a = 8'h05, b = 8'h03 → sum = 8'h08 with no stale carry.
2. Basic add: a = 8'h3C, b = 8'h0F, cin = 0, out_ready = 1 → out_valid high exactly 8 cycles after accept; sum = 8'h4B, cout = 0; in_ready low for 9 cycles.
3. Full carry ripple: a = 8'hFF, b = 8'h01, cin = 0 → sum = 8'h00, cout = 1. Then a = 8'hFF, b = 8'hFF, cin = 1 → sum = 8'hFF, cout = 1.
4. Backpressure: hold out_ready = 0 for 20 cycles after out_valid → sum and cout stable, in_ready = 0, and in_valid pulses in that window are ignored. Raise out_ready → IDLE next cycle.
5. Back-to-back: in_valid held high with 4 operand sets, out_ready = 1 → each result correct, accepts spaced exactly 10 cycles apart.
6. WIDTH = 1 instance: exhaustive over all 8 (a, b, cin) combinations → {cout, sum} = a + b + cin, out_valid 1 cycle after accept. Also a 1000-vector random self-checking run at WIDTH = 8.
